adder_cla_4bit: RTL and testbench

//  - 4-bit carry-lookahead adder: s = a + b + inC, carry out on outC. Datapath leaf for the ALU and

---
 rtl/adder_cla_4bit.sv | 80 ++++++++
 tb/tb_adder_cla_4bit.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/adder_cla_4bit.sv
// 4-bit carry-lookahead adder (bit 0 = MSB) with zero-latency sum/carry and a 1-cycle registered copy; no backpressure.
// Define ADDER_CLA_4BIT_OVF_EN to add the signed-overflow outputs ovf/ovfReg.
module adder_cla_4bit (
  input  logic       clk,
  input  logic       rst,
  input  logic [0:3] a,
  input  logic [0:3] b,
  input  logic       inC,
  output logic [0:3] s,
  output logic       outC,
  output logic       grpP,
  output logic       grpG,
  output logic [0:3] sReg,
  output logic       outCReg
`ifdef ADDER_CLA_4BIT_OVF_EN
  ,
  output logic       ovf,
  output logic       ovfReg
`endif
);

  logic [0:3] p;
  logic [0:3] g;
  logic [0:4] c;
  logic [0:3] s_reg_d, s_reg_q;
  logic       out_c_reg_d, out_c_reg_q;

  // Every carry is a flat sum of products over g/p/inC, so no carry depends on another.
  always_comb begin
    p = a ^ b;
    g = a & b;
    c = '0;
    c[4] = inC;
    c[3] = g[3] | (p[3] & inC);
    c[2] = g[2] | (p[2] & g[3]) | (p[2] & p[3] & inC);
    c[1] = g[1] | (p[1] & g[2]) | (p[1] & p[2] & g[3]) | (p[1] & p[2] & p[3] & inC);
    c[0] = g[0] | (p[0] & g[1]) | (p[0] & p[1] & g[2]) | (p[0] & p[1] & p[2] & g[3])
         | (p[0] & p[1] & p[2] & p[3] & inC);
    s    = p ^ c[1:4];
    outC = c[0];
    grpP = &p;
    grpG = g[0] | (p[0] & g[1]) | (p[0] & p[1] & g[2]) | (p[0] & p[1] & p[2] & g[3]);
    s_reg_d     = s;
    out_c_reg_d = c[0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_reg_q     <= 4'h0;
      out_c_reg_q <= 1'b0;
    end else begin
      s_reg_q     <= s_reg_d;
      out_c_reg_q <= out_c_reg_d;
    end
  end

  assign sReg    = s_reg_q;
  assign outCReg = out_c_reg_q;

`ifdef ADDER_CLA_4BIT_OVF_EN
  logic ovf_reg_d, ovf_reg_q;

  // Signed overflow: carry into the sign bit differs from carry out of it.
  always_comb begin
    ovf       = c[0] ^ c[1];
    ovf_reg_d = ovf;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_reg_q <= 1'b0;
    end else begin
      ovf_reg_q <= ovf_reg_d;
    end
  end

  assign ovfReg = ovf_reg_q;
`endif

endmodule

// File: tb/tb_adder_cla_4bit.sv
// Self-checking bench for adder_cla_4bit: exhaustive, directed and random vectors against an arithmetic reference.
module tb_adder_cla_4bit;

  logic       clk;
  logic       rst;
  logic [0:3] a;
  logic [0:3] b;
  logic       inC;
  logic [0:3] s;
  logic       outC;
  logic       grpP;
  logic       grpG;
  logic [0:3] sReg;
  logic       outCReg;
`ifdef ADDER_CLA_4BIT_OVF_EN
  logic       ovf;
  logic       ovfReg;
`endif

  int checks   = 0;
  int failures = 0;

  adder_cla_4bit dut (
    .clk     (clk),
    .rst     (rst),
    .a       (a),
    .b       (b),
    .inC     (inC),
    .s       (s),
    .outC    (outC),
    .grpP    (grpP),
    .grpG    (grpG),
    .sReg    (sReg),
    .outCReg (outCReg)
`ifdef ADDER_CLA_4BIT_OVF_EN
    ,
    .ovf     (ovf),
    .ovfReg  (ovfReg)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain unsigned arithmetic on the operand values.
  function automatic logic [4:0] ref_sum(input logic [0:3] av, input logic [0:3] bv, input logic cv);
    int t;
    t = int'(av) + int'(bv) + int'(cv);
    return 5'(t);
  endfunction

  function automatic logic ref_ovf(input logic [0:3] av, input logic [0:3] bv, input logic cv);
    int sa, sb, t;
    sa = (int'(av) >= 8) ? int'(av) - 16 : int'(av);
    sb = (int'(bv) >= 8) ? int'(bv) - 16 : int'(bv);
    t  = sa + sb + int'(cv);
    return (t > 7) || (t < -8);
  endfunction

  // Apply a vector at negedge, check combinational outputs, then check the captured copy after the edge.
  task automatic apply_vec(input logic [0:3] av, input logic [0:3] bv, input logic cv, input bit chk_reg);
    logic [4:0] r;
    @(negedge clk);
    a = av; b = bv; inC = cv;
    r = ref_sum(av, bv, cv);
    #1;
    check("s",    8'(s),    8'(r[3:0]));
    check("outC", 8'(outC), 8'(r[4]));
    check("grpP", 8'(grpP), 8'((av ^ bv) == 4'hF));
    check("grpG", 8'(grpG), 8'(int'(av) + int'(bv) >= 16));
`ifdef ADDER_CLA_4BIT_OVF_EN
    check("ovf",  8'(ovf),  8'(ref_ovf(av, bv, cv)));
`endif
    if (chk_reg) begin
      @(posedge clk);
      #1;
      check("sReg",    8'(sReg),    8'(r[3:0]));
      check("outCReg", 8'(outCReg), 8'(r[4]));
`ifdef ADDER_CLA_4BIT_OVF_EN
      check("ovfReg",  8'(ovfReg),  8'(ref_ovf(av, bv, cv)));
`endif
    end
  endtask

  initial begin
    logic [8:0] v;
    rst = 1'b1; a = 4'h0; b = 4'h0; inC = 1'b0;
    #1;
    check("rst_sReg",    8'(sReg),    8'h00);
    check("rst_outCReg", 8'(outCReg), 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases
    apply_vec(4'h0, 4'h0, 1'b0, 1'b1);
    apply_vec(4'hA, 4'h5, 1'b0, 1'b1);
    apply_vec(4'h0, 4'h5, 1'b1, 1'b1);
    apply_vec(4'h1, 4'hF, 1'b1, 1'b1);
    apply_vec(4'hF, 4'h0, 1'b1, 1'b1);
    apply_vec(4'h7, 4'h1, 1'b0, 1'b1);

    // Asynchronous reset mid-run
    apply_vec(4'hF, 4'hF, 1'b1, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_sReg",    8'(sReg),    8'h00);
    check("midrst_outCReg", 8'(outCReg), 8'h00);
    check("midrst_s",       8'(s),       8'h0F);
    check("midrst_outC",    8'(outC),    8'h01);
    @(posedge clk);
    #1;
    check("rsthold_sReg", 8'(sReg), 8'h00);
    check("rsthold_s",    8'(s),    8'h0F);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rel_sReg",    8'(sReg),    8'h0F);
    check("rel_outCReg", 8'(outCReg), 8'h01);

    // Exhaustive combinational sweep
    for (int i = 0; i < 512; i++) begin
      v = 9'(i);
      apply_vec(v[8:5], v[4:1], v[0], 1'b0);
    end

    // Random vectors with registered checks
    for (int i = 0; i < 300; i++) begin
      apply_vec(4'($urandom_range(15)), 4'($urandom_range(15)), 1'($urandom_range(1)), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
